dual_issue_redirect_ctrl: RTL and testbench

Control-flow sequencer for the dual-issue fetch front end. It arbitrates redirect requests (taken branch, JAL, JALR) from the two execute lanes, where lane 1 is always older in program order. It latches the winning target, drives the PC-pair load and enables, and kills wrong-path instructions in fetch, decode and the younger execute slot. It sits between the two execute stages, the hazard unit and the dual PC register.

---
 rtl/dual_issue_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_dual_issue_redirect_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_redirect_ctrl.sv
// dual_issue_redirect_ctrl: redirect sequencer for the dual-issue fetch front end.
// Lane 1 is the older instruction, so its redirect wins and squashes lane 2 in E.
// The winning word-aligned target is latched and then loaded into the PC pair.
// Issue is held while the new fetch pair refills.
// Optional feature: define REDIR_PERF_EN to build the saturating redirect counter.
// Without it, redir_count_o is tied to zero.
module dual_issue_redirect_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned REFILL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redir_valid1_i,
  input  logic [WIDTH-1:0] redir_target1_i,
  input  logic             redir_valid2_i,
  input  logic [WIDTH-1:0] redir_target2_i,
  input  logic             stall1_i,
  input  logic             stall2_i,
  input  logic             fetch_ready_i,
  output logic             en1_o,
  output logic             en2_o,
  output logic             pc_load_o,
  output logic [WIDTH-1:0] pc_load_addr_o,
  output logic             flush_fd_o,
  output logic             kill_e2_o,
  output logic             issue_hold_o,
  output logic             busy_o,
  output logic [31:0]      redir_count_o
);

  typedef enum logic [1:0] {StRun, StRedir, StRefill} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [2:0]       refill_cnt_q, refill_cnt_d;

  logic             redir_any;
  logic [WIDTH-1:0] win_target;
  logic             en;

  // The low target bits are discarded by alignment.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^{redir_target1_i[1:0], redir_target2_i[1:0]};

  assign redir_any  = redir_valid1_i | redir_valid2_i;
  assign win_target = redir_valid1_i ? {redir_target1_i[WIDTH-1:2], 2'b00}
                                     : {redir_target2_i[WIDTH-1:2], 2'b00};

  // Next-state and output decode; outputs are combinational from state and inputs.
  always_comb begin
    state_d        = state_q;
    pend_addr_d    = pend_addr_q;
    refill_cnt_d   = refill_cnt_q;
    en             = 1'b0;
    pc_load_o      = 1'b0;
    pc_load_addr_o = '0;
    flush_fd_o     = 1'b0;
    kill_e2_o      = 1'b0;
    issue_hold_o   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redir_any) begin
          // Redirect overrides any coincident stall.
          kill_e2_o   = redir_valid1_i;
          flush_fd_o  = 1'b1;
          pend_addr_d = win_target;
          state_d     = StRedir;
        end else begin
          en = ~(stall1_i | stall2_i);
        end
      end
      StRedir: begin
        pc_load_o      = 1'b1;
        pc_load_addr_o = pend_addr_q;
        flush_fd_o     = 1'b1;
        issue_hold_o   = 1'b1;
        en             = fetch_ready_i;
        if (fetch_ready_i) begin
          state_d      = StRefill;
          refill_cnt_d = 3'(REFILL_CYCLES - 1);
        end
      end
      StRefill: begin
        issue_hold_o = 1'b1;
        en           = ~(stall1_i | stall2_i);
        if (refill_cnt_q == 3'd0) begin
          state_d = StRun;
        end else begin
          refill_cnt_d = refill_cnt_q - 3'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign en1_o  = en;
  assign en2_o  = en;
  assign busy_o = (state_q != StRun);

  // State registers with synchronous reset; reset abandons any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      pend_addr_q  <= '0;
      refill_cnt_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

`ifdef REDIR_PERF_EN
  logic [31:0] redir_count_q;

  // Count RUN->REDIR transitions, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_count_q <= '0;
    end else if ((state_q == StRun) && redir_any && (redir_count_q != 32'hFFFF_FFFF)) begin
      redir_count_q <= redir_count_q + 32'd1;
    end
  end

  assign redir_count_o = redir_count_q;
`else
  assign redir_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_dual_issue_redirect_ctrl.sv
// Bench for dual_issue_redirect_ctrl: directed vector table, then random stimulus
// checked against a timeline-level reference model.
module tb_dual_issue_redirect_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned RC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          v1, v2, s1, s2, fr;
  logic [W-1:0]  t1, t2;
  logic          en1, en2, pcl, flush, kill, hold, busy;
  logic [W-1:0]  addr;
  logic [31:0]   cnt;

  always #5 clk = ~clk;

  dual_issue_redirect_ctrl #(
    .WIDTH        (W),
    .REFILL_CYCLES(RC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redir_valid1_i (v1),
    .redir_target1_i(t1),
    .redir_valid2_i (v2),
    .redir_target2_i(t2),
    .stall1_i       (s1),
    .stall2_i       (s2),
    .fetch_ready_i  (fr),
    .en1_o          (en1),
    .en2_o          (en2),
    .pc_load_o      (pcl),
    .pc_load_addr_o (addr),
    .flush_fd_o     (flush),
    .kill_e2_o      (kill),
    .issue_hold_o   (hold),
    .busy_o         (busy),
    .redir_count_o  (cnt)
  );

  // Environment: dual PC register loaded from the controller.
  logic [W-1:0] pc1 = '0, pc2 = '0;
  always @(posedge clk) begin
    if (pcl && en1) begin
      pc1 <= addr;
      pc2 <= addr + 32'd4;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input longint n);
`ifdef REDIR_PERF_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  typedef struct {
    logic        rst, v1;
    logic [31:0] t1;
    logic        v2;
    logic [31:0] t2;
    logic        s1, s2, fr;
    logic        en, pcl;
    logic [31:0] addr;
    logic        flush, kill, hold, busy;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a1, input logic [31:0] b1,
                              input logic a2, input logic [31:0] b2, input logic c1,
                              input logic c2, input logic f, input logic e, input logic p,
                              input logic [31:0] ad, input logic fl, input logic k,
                              input logic h, input logic b, input int n);
    vec_t v;
    v.rst = r; v.v1 = a1; v.t1 = b1; v.v2 = a2; v.t2 = b2; v.s1 = c1; v.s2 = c2; v.fr = f;
    v.en = e; v.pcl = p; v.addr = ad; v.flush = fl; v.kill = k; v.hold = h; v.busy = b;
    v.cnt = n;
    return v;
  endfunction

  function automatic logic [63:0] pack_out(input logic e1, input logic e2, input logic p,
                                           input logic [31:0] ad, input logic fl,
                                           input logic k, input logic h, input logic b);
    return {25'd0, e1, e2, p, ad, fl, k, h, b};
  endfunction

  vec_t vecs[23];

  // Timeline model: waiting for fetch acceptance, then a number of held cycles.
  bit          m_loading;
  int          m_hold;
  logic [31:0] m_tgt;
  longint      m_cnt;

  initial begin
    //          rst v1 t1            v2 t2          s1 s2 fr  en pcl addr          fl k  h  b  cnt
    vecs[0]  = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,            0, 0,          1, 0, 1,  0, 0, 0,            0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 32'h103,      0, 0,          0, 1, 1,  0, 0, 0,            1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 1, 32'h100,      1, 0, 1, 1, 1);
    vecs[4]  = mk(0, 1, 32'h999,      0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 1, 1, 1);
    vecs[5]  = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 32'h200,      1, 32'h300,    0, 0, 1,  0, 0, 0,            1, 1, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 1, 32'h200,      1, 0, 1, 1, 2);
    vecs[8]  = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 1, 1, 2);
    vecs[9]  = mk(0, 0, 0,            1, 32'h40,     0, 0, 1,  0, 0, 0,            1, 0, 0, 0, 2);
    vecs[10] = mk(0, 0, 0,            0, 0,          0, 0, 0,  0, 1, 32'h40,       1, 0, 1, 1, 3);
    vecs[11] = mk(0, 1, 32'h700,      0, 0,          0, 0, 0,  0, 1, 32'h40,       1, 0, 1, 1, 3);
    vecs[12] = mk(0, 0, 0,            0, 0,          0, 0, 0,  0, 1, 32'h40,       1, 0, 1, 1, 3);
    vecs[13] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 1, 32'h40,       1, 0, 1, 1, 3);
    vecs[14] = mk(0, 0, 0,            0, 0,          1, 0, 1,  0, 0, 0,            0, 0, 1, 1, 3);
    vecs[15] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 0, 0, 3);
    vecs[16] = mk(0, 1, 32'h500,      0, 0,          0, 0, 1,  0, 0, 0,            1, 1, 0, 0, 3);
    vecs[17] = mk(1, 0, 0,            0, 0,          0, 0, 1,  1, 1, 32'h500,      1, 0, 1, 1, 4);
    vecs[18] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 32'hFFFFFFFE, 0, 0,          0, 0, 1,  0, 0, 0,            1, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 1, 32'hFFFFFFFC, 1, 0, 1, 1, 1);
    vecs[21] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 1, 1, 1);
    vecs[22] = mk(0, 0, 0,            0, 0,          0, 0, 1,  1, 0, 0,            0, 0, 0, 0, 1);

    rst = 1'b1; v1 = 0; v2 = 0; t1 = '0; t2 = '0; s1 = 0; s2 = 0; fr = 1;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      rst = vecs[i].rst; v1 = vecs[i].v1; t1 = vecs[i].t1; v2 = vecs[i].v2;
      t2 = vecs[i].t2; s1 = vecs[i].s1; s2 = vecs[i].s2; fr = vecs[i].fr;
      #1;
      check($sformatf("vec%0d_out", i), pack_out(en1, en2, pcl, addr, flush, kill, hold, busy),
            pack_out(vecs[i].en, vecs[i].en, vecs[i].pcl, vecs[i].addr, vecs[i].flush,
                     vecs[i].kill, vecs[i].hold, vecs[i].busy));
      check($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(exp_cnt(vecs[i].cnt)));
      if (i == 4)  check("pc_pair_100", {pc1, pc2}, {32'h100, 32'h104});
      if (i == 14) check("pc_pair_40", {pc1, pc2}, {32'h40, 32'h44});
      if (i == 21) check("pc_pair_wrap", {pc1, pc2}, {32'hFFFFFFFC, 32'h0});
      @(posedge clk);
      #1;
    end

    // Random phase; the table ends idle in RUN with one counted redirect.
    m_loading = 0; m_hold = 0; m_tgt = '0; m_cnt = 1;
    for (int i = 0; i < 3000; i++) begin
      logic        e_en, e_pcl, e_fl, e_k, e_h, e_b;
      logic [31:0] e_ad;
      rst = ($urandom_range(0, 63) == 0);
      v1  = ($urandom_range(0, 3) == 0);
      v2  = ($urandom_range(0, 2) == 0);
      t1  = $urandom;
      t2  = $urandom;
      s1  = ($urandom_range(0, 4) == 0);
      s2  = ($urandom_range(0, 4) == 0);
      fr  = ($urandom_range(0, 3) != 0);
      #1;
      e_pcl = 0; e_ad = '0; e_fl = 0; e_k = 0; e_h = 0;
      if (m_loading) begin
        e_pcl = 1; e_ad = m_tgt; e_fl = 1; e_h = 1; e_en = fr;
      end else if (m_hold > 0) begin
        e_h = 1; e_en = !(s1 || s2);
      end else if (v1 || v2) begin
        e_k = v1; e_fl = 1; e_en = 0;
      end else begin
        e_en = !(s1 || s2);
      end
      e_b = m_loading || (m_hold > 0);
      check("rand_out", pack_out(en1, en2, pcl, addr, flush, kill, hold, busy),
            pack_out(e_en, e_en, e_pcl, e_ad, e_fl, e_k, e_h, e_b));
      check("rand_cnt", 64'(cnt), 64'(exp_cnt(m_cnt)));
      @(posedge clk);
      #1;
      if (rst) begin
        m_loading = 0; m_hold = 0; m_tgt = '0; m_cnt = 0;
      end else if (m_loading) begin
        if (fr) begin
          m_loading = 0;
          m_hold    = RC;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (v1 || v2) begin
        m_loading = 1;
        m_tgt     = (v1 ? t1 : t2) & 32'hFFFF_FFFC;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
